// File: rtl/median_scanner_if.sv
// Memory read port and filtered-pixel stream of the median scanner.
// The scanner drives the master side; memory and downstream sit on the slave side.
interface median_scanner_if;
  logic [7:0] memX;
  logic [7:0] memY;
  logic       memWrite;
  logic       memData;
  logic       pixOut;
  logic [7:0] pixX;
  logic [7:0] pixY;
  logic       pixValid;
  logic       pixReady;

  modport master (
    output memX, memY, memWrite, pixOut, pixX, pixY, pixValid,
    input  memData, pixReady
  );

  modport slave (
    input  memX, memY, memWrite, pixOut, pixX, pixY, pixValid,
    output memData, pixReady
  );
endinterface

// File: rtl/median_scanner.sv
// Raster-scans a 1-bit image, fetches each 3x3 neighbourhood through the x/y read
// port and streams the majority-of-9 pixel out over a valid/ready handshake.
module median_scanner #(
  parameter int IMWIDTH   = 240,
  parameter int IMHEIGHT  = 180,
  parameter int THRESHOLD = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  median_scanner_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUTPUT, DONE} stateT;

  typedef struct packed {
    logic       oob;
    logic [7:0] x;
    logic [7:0] y;
  } slotAddrT;

  stateT      state;
  logic [7:0] cx;
  logic [7:0] cy;
  logic [3:0] slot;
  logic [3:0] cnt;
  logic       curOob;
  logic       tagDly;
  logic       oobDly;

  slotAddrT   nxtAddr;
  slotAddrT   pixAddr;
  logic       wrapX;
  logic       lastPix;
  logic [7:0] nextCx;
  logic [7:0] nextCy;
  logic       accum;
  logic [3:0] cntNext;

  // Out-of-bounds slots read the centre pixel instead; their data is discarded.
  function automatic slotAddrT slotAddr(input logic [7:0] px, input logic [7:0] py,
                                        input logic [3:0] s);
    int dx;
    int dy;
    int xi;
    int yi;
    slotAddrT r;
    dx = int'(s % 4'd3) - 1;
    dy = int'(s / 4'd3) - 1;
    xi = int'(px) + dx;
    yi = int'(py) + dy;
    r.oob = (xi < 0) || (xi > IMWIDTH - 1) || (yi < 0) || (yi > IMHEIGHT - 1);
    r.x   = r.oob ? px : xi[7:0];
    r.y   = r.oob ? py : yi[7:0];
    return r;
  endfunction

  always_comb begin
    wrapX   = (cx == 8'(IMWIDTH - 1));
    lastPix = wrapX && (cy == 8'(IMHEIGHT - 1));
    nextCx  = wrapX ? 8'd0 : cx + 8'd1;
    nextCy  = wrapX ? cy + 8'd1 : cy;
    nxtAddr = slotAddr(cx, cy, slot + 4'd1);
    pixAddr = slotAddr(nextCx, nextCy, 4'd0);
    accum   = tagDly && !oobDly && bus.memData;
    cntNext = cnt + {3'b000, accum};
  end

  assign bus.memWrite = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cx           <= '0;
      cy           <= '0;
      slot         <= '0;
      cnt          <= '0;
      curOob       <= 1'b0;
      tagDly       <= 1'b0;
      oobDly       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.memX     <= '0;
      bus.memY     <= '0;
      bus.pixOut   <= 1'b0;
      bus.pixX     <= '0;
      bus.pixY     <= '0;
      bus.pixValid <= 1'b0;
    end else begin
      tagDly <= 1'b0;
      oobDly <= 1'b0;
      done   <= 1'b0;
      // Read data lags the address by one cycle, so the tag/flag pair does too.
      if (accum) begin
        cnt <= cntNext;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cx       <= '0;
            cy       <= '0;
            cnt      <= '0;
            slot     <= '0;
            busy     <= 1'b1;
            state    <= READ;
            bus.memX <= 8'd0;
            bus.memY <= 8'd0;
            curOob   <= 1'b1;
          end
        end
        READ: begin
          tagDly <= 1'b1;
          oobDly <= curOob;
          if (slot == 4'd8) begin
            state <= DRAIN;
          end else begin
            slot     <= slot + 4'd1;
            bus.memX <= nxtAddr.x;
            bus.memY <= nxtAddr.y;
            curOob   <= nxtAddr.oob;
          end
        end
        DRAIN: begin
          state        <= OUTPUT;
          bus.pixValid <= 1'b1;
          bus.pixOut   <= (int'(cntNext) >= THRESHOLD);
          bus.pixX     <= cx;
          bus.pixY     <= cy;
        end
        OUTPUT: begin
          if (bus.pixReady) begin
            bus.pixValid <= 1'b0;
            cnt          <= '0;
            if (lastPix) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= READ;
              slot     <= '0;
              cx       <= nextCx;
              cy       <= nextCy;
              bus.memX <= pixAddr.x;
              bus.memY <= pixAddr.y;
              curOob   <= pixAddr.oob;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_scanner.sv
// Scoreboard bench for median_scanner on a 4x3 image: expected pixels are queued
// when a scan is launched and popped by a monitor on every accepted output.
module tb_median_scanner;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start4;
  logic busy;
  logic done;
  logic busy4;
  logic done4;

  median_scanner_if bus ();
  median_scanner_if bus4 ();

  median_scanner #(.IMWIDTH(W), .IMHEIGHT(H), .THRESHOLD(5)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  median_scanner #(.IMWIDTH(W), .IMHEIGHT(H), .THRESHOLD(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4), .bus(bus4)
  );

  always #5 clk = ~clk;

  logic img [W*H];

  always @(posedge clk) begin
    bus.memData  <= img[int'(bus.memY) * W + int'(bus.memX)];
    bus4.memData <= img[int'(bus4.memY) * W + int'(bus4.memX)];
  end

  typedef struct {
    int x;
    int y;
    int p;
  } expT;

  expT q[$];
  expT q4[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    expT e;
    if (bus.pixValid && bus.pixReady) begin
      if (q.size() == 0) begin
        check("extra_pixel", 1, 0);
      end else begin
        e = q.pop_front();
        $display("pix (%0d,%0d) = %0d", bus.pixX, bus.pixY, bus.pixOut);
        check("pixX", int'(bus.pixX), e.x);
        check("pixY", int'(bus.pixY), e.y);
        check("pixOut", int'(bus.pixOut), e.p);
      end
    end
    if (bus4.pixValid && bus4.pixReady) begin
      if (q4.size() == 0) begin
        check("extra_pixel_t4", 1, 0);
      end else begin
        e = q4.pop_front();
        $display("pix4 (%0d,%0d) = %0d", bus4.pixX, bus4.pixY, bus4.pixOut);
        check("pixX_t4", int'(bus4.pixX), e.x);
        check("pixY_t4", int'(bus4.pixY), e.y);
        check("pixOut_t4", int'(bus4.pixOut), e.p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setImg(input logic [11:0] bits);
    for (int i = 0; i < W * H; i++) img[i] = bits[i];
  endtask

  task automatic pushExp(input logic [11:0] bits, input int count, input bit toQ4);
    expT e;
    for (int i = 0; i < count; i++) begin
      e.x = i % W;
      e.y = i / W;
      e.p = int'(bits[i]);
      if (toQ4) q4.push_back(e);
      else q.push_back(e);
    end
  endtask

  task automatic checkResetOuts(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pixValid"}, int'(bus.pixValid), 0);
    check({tag, "_pixOut"}, int'(bus.pixOut), 0);
    check({tag, "_pixX"}, int'(bus.pixX), 0);
    check({tag, "_pixY"}, int'(bus.pixY), 0);
    check({tag, "_memX"}, int'(bus.memX), 0);
    check({tag, "_memY"}, int'(bus.memY), 0);
    check({tag, "_memWrite"}, int'(bus.memWrite), 0);
  endtask

  task automatic runScan(input int cycles, input bit extraStarts,
                         output int firstV, output int doneAt, output int doneCnt);
    firstV  = -1;
    doneAt  = -1;
    doneCnt = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= cycles; n++) begin
      if (bus.pixValid && firstV < 0) firstV = n;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      if (bus.memWrite) check("memWrite_low", 1, 0);
      start = (extraStarts && (n == 30 || n == 100)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  localparam logic [11:0] ONES_EXP  = 12'b0110_1111_0110;
  localparam logic [11:0] BLOCK_T4  = 12'b0000_0110_0110;

  initial begin
    int firstV;
    int doneAt;
    int doneCnt;
    int n;
    int m;
    int changes;
    int seen;
    logic v0, p0;
    logic [7:0] x0, y0, mx0, my0;

    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    bus.pixReady = 1'b0;
    bus4.pixReady = 1'b1;
    setImg(12'h000);
    tick();
    checkResetOuts("reset");
    tick();
    reset = 1'b0;
    tick();

    // All ones, with stray start pulses mid-scan that must be ignored.
    setImg(12'hFFF);
    pushExp(ONES_EXP, 12, 1'b0);
    bus.pixReady = 1'b1;
    runScan(150, 1'b1, firstV, doneAt, doneCnt);
    $display("ones: firstValid=%0d done=%0d count=%0d", firstV, doneAt, doneCnt);
    check("ones_first_valid", firstV, 11);
    check("ones_done_cycle", doneAt, 133);
    check("ones_done_count", doneCnt, 1);
    check("ones_queue_empty", q.size(), 0);
    q.delete();

    // Isolated salt pixel is removed.
    setImg(12'h020);
    pushExp(12'h000, 12, 1'b0);
    runScan(150, 1'b0, firstV, doneAt, doneCnt);
    $display("salt: done=%0d", doneAt);
    check("salt_done_cycle", doneAt, 133);
    check("salt_queue_empty", q.size(), 0);
    q.delete();

    // 2x2 block: four ones is below threshold 5.
    setImg(12'h066);
    pushExp(12'h000, 12, 1'b0);
    runScan(150, 1'b0, firstV, doneAt, doneCnt);
    $display("block t5: done=%0d", doneAt);
    check("block_done_cycle", doneAt, 133);
    check("block_queue_empty", q.size(), 0);
    q.delete();

    // Same block against threshold 4.
    pushExp(BLOCK_T4, 12, 1'b1);
    tick();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 200) begin
      tick();
      n++;
    end
    $display("block t4: done=%0d", n);
    check("t4_done_cycle", n, 133);
    check("t4_queue_empty", q4.size(), 0);
    q4.delete();

    // Backpressure on the first pixel.
    setImg(12'hFFF);
    pushExp(ONES_EXP, 12, 1'b0);
    bus.pixReady = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!bus.pixValid && n < 40) begin
      tick();
      n++;
    end
    check("bp_first_valid", n, 11);
    v0 = bus.pixValid; p0 = bus.pixOut; x0 = bus.pixX; y0 = bus.pixY;
    mx0 = bus.memX; my0 = bus.memY;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pixValid !== v0 || bus.pixOut !== p0 || bus.pixX !== x0 ||
          bus.pixY !== y0 || bus.memX !== mx0 || bus.memY !== my0)
        changes++;
    end
    $display("backpressure: held 20 cycles, changes=%0d", changes);
    check("bp_stable", changes, 0);
    check("bp_valid_held", int'(v0), 1);
    bus.pixReady = 1'b1;
    tick();
    m = 1;
    while (!bus.pixValid && m < 40) begin
      tick();
      m++;
    end
    $display("backpressure: next valid after %0d cycles", m);
    check("bp_next_valid", m, 11);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("bp_done_seen", int'(done), 1);
    check("bp_queue_empty", q.size(), 0);
    q.delete();
    tick();

    // Reset while pixel (2,1) is being read.
    pushExp(ONES_EXP, 6, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (n = 1; n < 70; n++) tick();
    check("rst_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    checkResetOuts("midreset");
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.pixValid || done || busy) seen++;
    end
    $display("mid-scan reset: activity afterwards=%0d", seen);
    check("rst_no_activity", seen, 0);
    check("rst_queue_empty", q.size(), 0);
    q.delete();

    pushExp(ONES_EXP, 12, 1'b0);
    runScan(150, 1'b0, firstV, doneAt, doneCnt);
    $display("rescan: firstValid=%0d done=%0d", firstV, doneAt);
    check("rescan_first_valid", firstV, 11);
    check("rescan_done_cycle", doneAt, 133);
    check("rescan_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
